// File: rtl/fp_muldiv_pkg.sv
// Shared encodings for the FrontPanel wire-driven arithmetic engine.
// Optional feature: FP_MULDIV_OPCOUNT_EN adds a completed-operation counter in status[31:16].
package fp_muldiv_pkg;

    // Opcode encodings carried in ctrl_in[3:2] and reported in status[4:3]
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // ctrl_in bit positions
    localparam int unsigned CtrlStart = 0;
    localparam int unsigned CtrlClear = 1;
    localparam int unsigned CtrlOpLo  = 2;
    localparam int unsigned CtrlOpHi  = 3;

    // status bit positions
    localparam int unsigned StatBusy    = 0;
    localparam int unsigned StatDone    = 1;
    localparam int unsigned StatDivZero = 2;
    localparam int unsigned StatOpLo    = 3;
    localparam int unsigned StatOpHi    = 4;
    localparam int unsigned StatCntLo   = 16;
    localparam int unsigned StatCntHi   = 31;

endpackage

// File: rtl/fp_wire_muldiv_if.sv
// WireIn/WireOut bundle between the FrontPanel endpoints and the arithmetic engine.
interface fp_wire_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic [31:0]      ctrl_in;
    logic [WIDTH-1:0] opa_in;
    logic [WIDTH-1:0] opb_in;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [31:0]      status;

    // Host side: WireIn writer and WireOut reader
    modport master (
        output ctrl_in,
        output opa_in,
        output opb_in,
        input  result_lo,
        input  result_hi,
        input  status
    );

    // Engine side
    modport slave (
        input  ctrl_in,
        input  opa_in,
        input  opb_in,
        output result_lo,
        output result_hi,
        output status
    );
endinterface

// File: rtl/fp_muldiv_iter.sv
// Bit-serial datapath: shift-add multiply and restoring divide, one bit per step.
// hi_next_o/lo_next_o give the value after the current step so the caller can
// register the final result on the same edge as the last step.
module fp_muldiv_iter
    import fp_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_next_o,
    output logic [WIDTH-1:0] lo_next_o
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // MUL: hi = partial product, lo = multiplier shifting out, m = multiplicand
    // DIV: hi = remainder, lo = dividend shifting out / quotient shifting in, m = divisor
    logic [WIDTH-1:0] hi_q, lo_q, m_q;
    logic             div_q;
    logic [CntW-1:0]  cnt_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    // Next-step value for whichever operation is loaded
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_q};
        // Remainder stays below the divisor, so the top bit is a pure borrow flag
        div_ge    = ~div_diff[WIDTH];
        if (div_q) begin
            hi_next_o = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_next_o = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            hi_next_o = mul_sum[WIDTH:1];
            lo_next_o = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign last_o = (cnt_q == CntW'(WIDTH - 1));

    // Working registers: load on launch, advance one bit per step
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            hi_q  <= '0;
            lo_q  <= is_div_i ? opa_i : opb_i;
            m_q   <= is_div_i ? opb_i : opa_i;
            div_q <= is_div_i;
            cnt_q <= '0;
        end else if (step_i) begin
            hi_q  <= hi_next_o;
            lo_q  <= lo_next_o;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/fp_wire_muldiv.sv
// FrontPanel wire-driven arithmetic engine: edge-triggered ADD/SUB/MUL/DIV launched from
// level-style WireIn writes, with results held stable for asynchronous WireOut sampling.
// Optional feature: FP_MULDIV_OPCOUNT_EN adds a completed-operation counter in status[31:16].
module fp_wire_muldiv
    import fp_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              okClk,
    input  logic              rst_n,
    fp_wire_muldiv_if.slave   bus
);
    state_e           state_q, state_d;
    logic             start_q;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [1:0]       last_op_q, last_op_d;

    logic             start_edge, clear, complete;
    logic [1:0]       op_in;
    logic [WIDTH:0]   add_sum, sub_diff;
    logic             iter_load, iter_step, iter_last;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic [15:0]      opcount;
    logic             unused_ctrl;

    assign clear       = bus.ctrl_in[CtrlClear];
    assign op_in       = bus.ctrl_in[CtrlOpHi:CtrlOpLo];
    assign start_edge  = bus.ctrl_in[CtrlStart] & ~start_q;
    assign unused_ctrl = ^bus.ctrl_in[31:4];

    fp_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk_i     (okClk),
        .rst_ni    (rst_n),
        .load_i    (iter_load),
        .step_i    (iter_step),
        .is_div_i  (op_in == OP_DIV),
        .opa_i     (bus.opa_in),
        .opb_i     (bus.opb_in),
        .last_o    (iter_last),
        .hi_next_o (iter_hi),
        .lo_next_o (iter_lo)
    );

    // FSM next state, operand capture and result/status updates
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        done_d    = done_q;
        dz_d      = dz_q;
        last_op_d = last_op_q;
        iter_load = 1'b0;
        iter_step = 1'b0;
        complete  = 1'b0;
        add_sum   = {1'b0, a_q} + {1'b0, b_q};
        sub_diff  = {1'b0, a_q} - {1'b0, b_q};

        if (clear) begin
            // Level clear overrides everything, including a coincident start edge
            state_d = StIdle;
            lo_d    = '0;
            hi_d    = '0;
            done_d  = 1'b0;
            dz_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_edge) begin
                        op_d      = op_in;
                        a_d       = bus.opa_in;
                        b_d       = bus.opb_in;
                        last_op_d = op_in;
                        done_d    = 1'b0;
                        dz_d      = 1'b0;
                        iter_load = 1'b1;
                        state_d   = StRun;
                    end
                end
                StRun: begin
                    unique case (op_q)
                        OP_ADD: begin
                            lo_d     = add_sum[WIDTH-1:0];
                            hi_d     = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
                            complete = 1'b1;
                        end
                        OP_SUB: begin
                            lo_d     = sub_diff[WIDTH-1:0];
                            hi_d     = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH]};
                            complete = 1'b1;
                        end
                        default: begin
                            if (op_q == OP_DIV && b_q == '0) begin
                                lo_d     = '1;
                                hi_d     = a_q;
                                dz_d     = 1'b1;
                                complete = 1'b1;
                            end else begin
                                iter_step = 1'b1;
                                if (iter_last) begin
                                    lo_d     = iter_lo;
                                    hi_d     = iter_hi;
                                    complete = 1'b1;
                                end
                            end
                        end
                    endcase
                    if (complete) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers; start_q resets high so a held start cannot launch
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            start_q   <= 1'b1;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            last_op_q <= OP_ADD;
        end else begin
            state_q   <= state_d;
            start_q   <= bus.ctrl_in[CtrlStart];
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            last_op_q <= last_op_d;
        end
    end

`ifdef FP_MULDIV_OPCOUNT_EN
    logic [15:0] opcount_q, opcount_d;

    // Count completions only; aborts never reach complete
    always_comb begin
        opcount_d = opcount_q;
        if (clear) begin
            opcount_d = '0;
        end else if (complete) begin
            opcount_d = opcount_q + 16'd1;
        end
    end

    // Completed-operation counter register
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            opcount_q <= '0;
        end else begin
            opcount_q <= opcount_d;
        end
    end

    assign opcount = opcount_q;
`else
    assign opcount = '0;
`endif

    // WireOut presentation
    always_comb begin
        bus.status                       = '0;
        bus.status[StatBusy]             = (state_q == StRun);
        bus.status[StatDone]             = done_q;
        bus.status[StatDivZero]          = dz_q;
        bus.status[StatOpHi:StatOpLo]    = last_op_q;
        bus.status[StatCntHi:StatCntLo]  = opcount;
        bus.result_lo                    = lo_q;
        bus.result_hi                    = hi_q;
    end

endmodule
